pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Registered ID-stage decoder for the pipelined RV32I core. Decodes one
//  instruction per accepted handshake into the same control bundle the
//  single-cycle decoder produces, and holds it in the ID/EX register.
//  Inserts load-use bubbles and, optionally, multi-cycle MUL/DIV occupancy.
//  Sits between the IF/ID register (upstream) and the execute stage (downstream).
// PARAMETERS
//  LOAD_USE_BUBBLES  1   bubbles inserted on a load-use hazard (legal 0..3)
//  MUL_LATENCY       2   execute cycles for MUL* (>=1; RV32M_EN only)
//  DIV_LATENCY       16  execute cycles for DIV*/REM* (>=1; RV32M_EN only)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous reset, active-low
//  flush        in   1   synchronous kill of the ID/EX register (branch/jump taken)
//  in_valid     in   1   instr is valid
//  in_ready     out  1   decoder accepts instr this cycle
//  instr        in   32  instruction word
//  out_valid    out  1   control bundle valid for execute
//  ex_ready     in   1   execute consumes the bundle this cycle
//  ALUControl   out  4   ALU operation, existing ALU-decoder encoding
//  ALUSrc, MemWrite, RegWrite, Branch, Jump, memUnsigned  out 1 each
//  ResultSrc    out  2   00 ALU, 01 mem, 10 PC+4
//  ImmSrc       out  3   000 I, 001 S, 010 B, 011 U(LUI), 100 U/J
//  memSize      out  2   00 byte, 01 half, 10 word
//  branchType   out  3   funct3 of branch
//  rd, rs1, rs2 out  5   register indices (rs2 = 0 for non-R/S/B)
//  mdu_op       out  1   bundle is an M-extension op (0 when RV32M_EN undefined)
//  mdu_funct    out  3   funct3 of M op
//  illegal      out  1   unsupported opcode/funct; bundle has RegWrite=MemWrite=Branch=Jump=0
// BEHAVIOUR
//  - Reset: all outputs 0 except memSize=2'b10; state RUN; counter 0; in_ready=1 after release.
//  - Decode: identical to the single-cycle table (R, I-ALU, load, store, B, LUI, AUIPC, JAL, JALR).
//  - Latency: bundle appears 1 cycle after accept (in_valid & in_ready).
//  - Register updates on accept; holds while out_valid & !ex_ready; out_valid drops
//    to 0 when consumed with no new accept.
//  - FSM states RUN, LU_BUBBLE, MDU_WAIT.
//  - RUN: in_ready = !out_valid | ex_ready, unless a hazard is detected.
//  - Load-use hazard: held bundle is a load with rd!=0 and incoming instr reads
//    that rd as rs1 (or as rs2 for R/S/B). Then in_ready=0 and, once consumed,
//    out_valid=0 for LOAD_USE_BUBBLES cycles (LU_BUBBLE), then RUN accepts the
//    held instr. LOAD_USE_BUBBLES=0 disables detection.
//  - MDU_WAIT: entered when an M-op bundle is consumed; in_ready=0, out_valid=0
//    for LATENCY-1 cycles (counter counts down to 0), then RUN.
//  - Counter width $clog2(max(DIV_LATENCY,MUL_LATENCY,LOAD_USE_BUBBLES)+1); no wrap.
//  - flush: next edge out_valid=0, state RUN, counter 0; overrides accept, hazard and
//    MDU wait; instr presented in the flush cycle is dropped (in_ready still asserted).
//  - rst_n low mid-operation: immediate return to reset values, any pending op lost.
//  - rd=x0 never creates a hazard; illegal bundles still flow (trap handled in EX).
// CONFIGURATION
//  RV32M_EN defined: opcode 0110011 with funct7=0000001 decodes as M op (mdu_op=1,
//   RegWrite=1, ResultSrc=00), MUL* use MUL_LATENCY, DIV*/REM* use DIV_LATENCY.
//  RV32M_EN undefined: those encodings set illegal=1; MDU_WAIT unreachable; mdu_op=0.
// TESTING
//  addi x1,x0,5 (0x00500093), ex_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUSrc=1, rd=1.
//  lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3) -> lw bundle, 1 bubble, add bundle; in_ready low 1 cycle.
//  ex_ready=0 for 3 cycles with valid bundle -> bundle stable, in_ready=0; released -> next accepted.
//  flush while add held and addi offered -> out_valid=0 next cycle, addi dropped, state RUN.
//  0xFFFFFFFF -> illegal=1, RegWrite=0, MemWrite=0, Jump=0.
//  RV32M_EN: div x5,x6,x7 (0x027342B3) -> mdu_op=1, mdu_funct=100, then 15 cycles in_ready=0; undefined -> illegal=1.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Registered ID-stage decoder: RV32I control bundle held in the ID/EX register,
// with load-use bubbles and optional RV32M decode/occupancy (define RV32M_EN).
module pipelined_control_unit #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MUL_LATENCY      = 2,
    parameter int DIV_LATENCY      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        ex_ready,
    output logic [3:0]  ALUControl,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        memUnsigned,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  memSize,
    output logic [2:0]  branchType,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        mdu_op,
    output logic [2:0]  mdu_funct,
    output logic        illegal
);
    localparam int LAT_MAX  = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
    localparam int WAIT_MAX = (LAT_MAX > LOAD_USE_BUBBLES) ? LAT_MAX : LOAD_USE_BUBBLES;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {RUN, LU_BUBBLE, MDU_WAIT} state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_t;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       mem_unsigned;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [1:0] mem_size;
        logic [2:0] branch_type;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mdu_op;
        logic [2:0] mdu_funct;
        logic       illegal;
        logic       is_load;
    } bundle_t;

    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    bundle_t             bundle_q, bundle_d, dec;
    logic [6:0]          opcode, funct7;
    logic [2:0]          funct3;
    logic                lu_hazard, mdu_block;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec          = '0;
        dec.mem_size = 2'b10;
        dec.rd       = instr[11:7];
        dec.rs1      = instr[19:15];
        case (opcode)
            7'b0110011: begin
                dec.rs2 = instr[24:20];
                if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
                    dec.mdu_op    = 1'b1;
                    dec.mdu_funct = funct3;
                    dec.reg_write = 1'b1;
`else
                    dec.illegal   = 1'b1;
`endif
                end else if (funct7 == 7'b0 ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.reg_write   = 1'b1;
                    dec.alu_control = alu_sel(funct3, funct7[5]);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                dec.alu_src = 1'b1;
                if ((funct3 == 3'b001 && funct7 != 7'b0) ||
                    (funct3 == 3'b101 && funct7 != 7'b0 && funct7 != 7'b0100000)) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write   = 1'b1;
                    dec.alu_control = alu_sel(funct3, (funct3 == 3'b101) && funct7[5]);
                end
            end
            7'b0000011: begin
                dec.alu_src      = 1'b1;
                dec.result_src   = 2'b01;
                dec.mem_size     = funct3[1:0];
                dec.mem_unsigned = funct3[2];
                dec.reg_write    = 1'b1;
                dec.is_load      = 1'b1;
                dec.illegal      = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
            end
            7'b0100011: begin
                dec.rs2       = instr[24:20];
                dec.rd        = '0;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'b001;
                dec.mem_size  = funct3[1:0];
                dec.mem_write = 1'b1;
                dec.illegal   = funct3[2] || (funct3[1:0] == 2'b11);
            end
            7'b1100011: begin
                dec.rs2         = instr[24:20];
                dec.rd          = '0;
                dec.imm_src     = 3'b010;
                dec.alu_control = ALU_SUB;
                dec.branch_type = funct3;
                dec.branch      = 1'b1;
                dec.illegal     = (funct3[2:1] == 2'b01);
            end
            7'b0110111: begin
                dec.rs1         = '0;
                dec.alu_src     = 1'b1;
                dec.imm_src     = 3'b011;
                dec.alu_control = ALU_PASSB;
                dec.reg_write   = 1'b1;
            end
            7'b0010111: begin
                dec.rs1       = '0;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'b100;
                dec.reg_write = 1'b1;
            end
            7'b1101111: begin
                dec.rs1        = '0;
                dec.imm_src    = 3'b100;
                dec.result_src = 2'b10;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
            end
            7'b1100111: begin
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.illegal    = (funct3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal bundles still flow to EX but must have no architectural side effects.
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.is_load   = 1'b0;
        end
    end

    assign lu_hazard = (LOAD_USE_BUBBLES > 0) && in_valid && out_valid_q && bundle_q.is_load &&
                       (bundle_q.rd != '0) && ((dec.rs1 == bundle_q.rd) || (dec.rs2 == bundle_q.rd));
    assign mdu_block = out_valid_q && bundle_q.mdu_op &&
                       (bundle_q.mdu_funct[2] ? (DIV_LATENCY > 1) : (MUL_LATENCY > 1));

    // Wait states load N-1 (bubbles) / LAT-2 (MDU); the count==0 cycle already accepts.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        in_ready    = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = (!out_valid_q || ex_ready) && !lu_hazard && !mdu_block;
                if (in_valid && in_ready) begin
                    bundle_d    = dec;
                    out_valid_d = 1'b1;
                end else if (out_valid_q && ex_ready) begin
                    out_valid_d = 1'b0;
                    if (lu_hazard) begin
                        state_d = LU_BUBBLE;
                        cnt_d   = CNT_W'(LOAD_USE_BUBBLES - 1);
                    end else if (mdu_block) begin
                        state_d = MDU_WAIT;
                        cnt_d   = bundle_q.mdu_funct[2] ? CNT_W'(DIV_LATENCY - 2)
                                                        : CNT_W'(MUL_LATENCY - 2);
                    end
                end
            end
            LU_BUBBLE, MDU_WAIT: begin
                if (cnt_q == '0) begin
                    in_ready = 1'b1;
                    state_d  = RUN;
                    if (in_valid) begin
                        bundle_d    = dec;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (flush) begin
            in_ready    = 1'b1;
            out_valid_d = 1'b0;
            bundle_d    = bundle_q;
            state_d     = RUN;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= RUN;
            cnt_q             <= '0;
            out_valid_q       <= 1'b0;
            bundle_q          <= '0;
            bundle_q.mem_size <= 2'b10;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign ALUControl  = bundle_q.alu_control;
    assign ALUSrc      = bundle_q.alu_src;
    assign MemWrite    = bundle_q.mem_write;
    assign RegWrite    = bundle_q.reg_write;
    assign Branch      = bundle_q.branch;
    assign Jump        = bundle_q.jump;
    assign memUnsigned = bundle_q.mem_unsigned;
    assign ResultSrc   = bundle_q.result_src;
    assign ImmSrc      = bundle_q.imm_src;
    assign memSize     = bundle_q.mem_size;
    assign branchType  = bundle_q.branch_type;
    assign rd          = bundle_q.rd;
    assign rs1         = bundle_q.rs1;
    assign rs2         = bundle_q.rs2;
    assign mdu_op      = bundle_q.mdu_op;
    assign mdu_funct   = bundle_q.mdu_funct;
    assign illegal     = bundle_q.illegal;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed self-checking bench for pipelined_control_unit (default parameters).
module tb_pipelined_control_unit;
    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, ex_ready;
    logic [31:0] instr;
    logic [3:0]  ALUControl;
    logic        ALUSrc, MemWrite, RegWrite, Branch, Jump, memUnsigned, mdu_op, illegal;
    logic [1:0]  ResultSrc, memSize;
    logic [2:0]  ImmSrc, branchType, mdu_funct;
    logic [4:0]  rd, rs1, rs2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] ADD  = 32'h002101B3;
    localparam logic [31:0] DIV  = 32'h027342B3;

    logic [31:0] tv_instr [8];
    logic [13:0] tv_ctl   [8];
    logic [14:0] tv_regs  [8];
    logic [13:0] ctl;
    logic [14:0] regs;

    pipelined_control_unit #(.LOAD_USE_BUBBLES(1), .MUL_LATENCY(2), .DIV_LATENCY(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .ex_ready(ex_ready), .ALUControl(ALUControl),
        .ALUSrc(ALUSrc), .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch),
        .Jump(Jump), .memUnsigned(memUnsigned), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .memSize(memSize), .branchType(branchType), .rd(rd), .rs1(rs1), .rs2(rs2),
        .mdu_op(mdu_op), .mdu_funct(mdu_funct), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    assign ctl  = {RegWrite, MemWrite, Branch, Jump, ALUSrc, ResultSrc, ImmSrc, memSize, memUnsigned, illegal};
    assign regs = {rs1, rs2, rd};

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [46:0] got;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b0; instr = '0;
        #12;
        got = {out_valid, ALUControl, ALUSrc, MemWrite, RegWrite, Branch, Jump, memUnsigned,
               ResultSrc, ImmSrc, memSize, branchType, rd, rs1, rs2, mdu_op, mdu_funct, illegal};
        n_checks++;
        if (got !== {1'b0, 4'b0, 6'b0, 2'b0, 3'b0, 2'b10, 3'b0, 15'b0, 1'b0, 3'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected memSize=2 others 0", got);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_addi();
        ex_ready = 1'b1; in_valid = 1'b1; instr = ADDI;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, RegWrite, ALUSrc, rd, ALUControl, illegal} !== {1'b1, 1'b1, 1'b1, 5'd1, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL addi_bundle: got v=%b rw=%b as=%b rd=%0d alu=%0d il=%b expected 1 1 1 1 0 0",
                               out_valid, RegWrite, ALUSrc, rd, ALUControl, illegal);
        end
        cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_load_use();
        ex_ready = 1'b1; in_valid = 1'b1; instr = LW;
        cycle();
        instr = ADD;
        #1;
        n_checks++;
        if ({out_valid, ResultSrc, rd, in_ready} !== {1'b1, 2'b01, 5'd2, 1'b0}) begin
            n_fail++; $display("FAIL lu_stall: got v=%b rs=%b rd=%0d rdy=%b expected 1 01 2 0",
                               out_valid, ResultSrc, rd, in_ready);
        end
        cycle();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL lu_bubble: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, RegWrite, ALUSrc, ResultSrc, regs} !== {1'b1, 1'b1, 1'b0, 2'b00, 5'd2, 5'd2, 5'd3}) begin
            n_fail++; $display("FAIL lu_add_bundle: got v=%b rw=%b regs=%h expected v=1 rw=1 rs1=2 rs2=2 rd=3",
                               out_valid, RegWrite, regs);
        end
        cycle();
        // lw x0 followed by add reading x0: no hazard, back-to-back accept
        in_valid = 1'b1; instr = 32'h0000A003;
        cycle();
        instr = 32'h000001B3;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b11) begin
            n_fail++; $display("FAIL lu_x0_no_hazard: got v=%b rdy=%b expected 1 1", out_valid, in_ready);
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, rd, ResultSrc} !== {1'b1, 5'd3, 2'b00}) begin
            n_fail++; $display("FAIL lu_x0_next: got v=%b rd=%0d rs=%b expected 1 3 00", out_valid, rd, ResultSrc);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0; in_valid = 1'b1; instr = ADDI;
        cycle();
        instr = ADD;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({out_valid, rd, RegWrite, in_ready} !== {1'b1, 5'd1, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v=%b rd=%0d rw=%b rdy=%b expected 1 1 1 0",
                                   i, out_valid, rd, RegWrite, in_ready);
            end
            cycle();
        end
        ex_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, rd} !== {1'b1, 5'd3}) begin
            n_fail++; $display("FAIL bp_next: got v=%b rd=%0d expected 1 3", out_valid, rd);
        end
        cycle();
    endtask

    task automatic test_flush();
        ex_ready = 1'b0; in_valid = 1'b1; instr = ADD;
        cycle();
        instr = ADDI; flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b expected 0", out_valid); end
        cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b expected 0", out_valid); end
        in_valid = 1'b1; instr = ADDI; ex_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, rd, ALUSrc} !== {1'b1, 5'd1, 1'b1}) begin
            n_fail++; $display("FAIL flush_resume: got v=%b rd=%0d as=%b expected 1 1 1", out_valid, rd, ALUSrc);
        end
        cycle();
    endtask

    task automatic test_decode_table();
        tv_instr = '{32'h0020A223, 32'h00208463, 32'h010000EF, 32'h0000C203,
                     32'h123452B7, 32'h00001317, 32'h000100E7, 32'h40628233};
        tv_ctl   = '{{5'b01001, 2'b00, 3'b001, 2'b10, 2'b00},
                     {5'b00100, 2'b00, 3'b010, 2'b10, 2'b00},
                     {5'b10010, 2'b10, 3'b100, 2'b10, 2'b00},
                     {5'b10001, 2'b01, 3'b000, 2'b00, 2'b10},
                     {5'b10001, 2'b00, 3'b011, 2'b10, 2'b00},
                     {5'b10001, 2'b00, 3'b100, 2'b10, 2'b00},
                     {5'b10011, 2'b10, 3'b000, 2'b10, 2'b00},
                     {5'b10000, 2'b00, 3'b000, 2'b10, 2'b00}};
        tv_regs  = '{{5'd1, 5'd2, 5'd0}, {5'd1, 5'd2, 5'd0}, {5'd0, 5'd0, 5'd1}, {5'd1, 5'd0, 5'd4},
                     {5'd0, 5'd0, 5'd5}, {5'd0, 5'd0, 5'd6}, {5'd2, 5'd0, 5'd1}, {5'd5, 5'd6, 5'd4}};
        ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; instr = tv_instr[i];
            cycle();
            n_checks++;
            if ({out_valid, ctl} !== {1'b1, tv_ctl[i]}) begin
                n_fail++; $display("FAIL decode_ctl_%0d: got v=%b ctl=%b expected v=1 ctl=%b",
                                   i, out_valid, ctl, tv_ctl[i]);
            end
            n_checks++;
            if (regs !== tv_regs[i]) begin
                n_fail++; $display("FAIL decode_regs_%0d: got %h expected %h", i, regs, tv_regs[i]);
            end
        end
        n_checks++;
        if (branchType !== 3'b000) begin n_fail++; $display("FAIL decode_branch_type: got %b expected 000", branchType); end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_illegal();
        ex_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFFFFFFF;
        cycle();
        instr = 32'h40109093;
        n_checks++;
        if ({out_valid, illegal, RegWrite, MemWrite, Jump, Branch} !== 6'b110000) begin
            n_fail++; $display("FAIL illegal_ones: got v=%b il=%b rw=%b mw=%b j=%b b=%b expected 1 1 0 0 0 0",
                               out_valid, illegal, RegWrite, MemWrite, Jump, Branch);
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, illegal, RegWrite} !== 3'b110) begin
            n_fail++; $display("FAIL illegal_slli_f7: got v=%b il=%b rw=%b expected 1 1 0", out_valid, illegal, RegWrite);
        end
        cycle();
    endtask

    task automatic test_mdu();
        ex_ready = 1'b1; in_valid = 1'b1; instr = DIV;
        cycle();
        instr = ADDI;
        #1;
`ifdef RV32M_EN
        n_checks++;
        if ({out_valid, mdu_op, mdu_funct, RegWrite, ResultSrc, illegal, in_ready} !== {1'b1, 1'b1, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL mdu_div_bundle: got v=%b m=%b f=%b rw=%b il=%b rdy=%b expected 1 1 100 1 0 0",
                               out_valid, mdu_op, mdu_funct, RegWrite, illegal, in_ready);
        end
        for (int i = 0; i < 14; i++) begin
            cycle();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b00) begin
                n_fail++; $display("FAIL mdu_wait_%0d: got v=%b rdy=%b expected 0 0", i, out_valid, in_ready);
            end
        end
        cycle();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mdu_done: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        cycle();
        instr = DIV;
        n_checks++;
        if ({out_valid, rd, mdu_op} !== {1'b1, 5'd1, 1'b0}) begin
            n_fail++; $display("FAIL mdu_next: got v=%b rd=%0d m=%b expected 1 1 0", out_valid, rd, mdu_op);
        end
        cycle();
        instr = ADDI;
        cycle();
        cycle();
        flush = 1'b1;
        #1;
        cycle();
        flush = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL mdu_flush: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
`else
        n_checks++;
        if ({out_valid, illegal, mdu_op, RegWrite, in_ready} !== 5'b11001) begin
            n_fail++; $display("FAIL mdu_disabled: got v=%b il=%b m=%b rw=%b rdy=%b expected 1 1 0 0 1",
                               out_valid, illegal, mdu_op, RegWrite, in_ready);
        end
`endif
        in_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0; in_valid = 1'b1; instr = LW;
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, RegWrite, ResultSrc, memSize, rd} !== {1'b0, 1'b0, 2'b00, 2'b10, 5'd0}) begin
            n_fail++; $display("FAIL arst_clear: got v=%b rw=%b rs=%b ms=%b rd=%0d expected 0 0 00 10 0",
                               out_valid, RegWrite, ResultSrc, memSize, rd);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        ex_ready = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL arst_release: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_backpressure();
        test_flush();
        test_decode_table();
        test_illegal();
        test_mdu();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
